// File: rtl/vote_session_ctrl.sv
// Ballot sequencer: session open/close, one armed ballot per officer authorisation,
// button debounce with multi-press rejection, and a single clean vote pulse per voter.
module vote_session_ctrl #(
  parameter int DEB_CYC = 4,
  parameter int TMO_CYC = 64,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sess_open,
  input  logic             sess_close,
  input  logic             voter_auth,
  input  logic             btn_A,
  input  logic             btn_B,
  input  logic             btn_C,
  output logic             vote_A,
  output logic             vote_B,
  output logic             vote_C,
  output logic             ready_led,
  output logic             sess_active,
  output logic             timeout,
  output logic [CNT_W-1:0] voters,
  output logic [CNT_W-1:0] rejects
);

  localparam int TW = $clog2(TMO_CYC + 1);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam logic [TW-1:0] TMO_LOAD = TW'(TMO_CYC - 1);
  localparam logic [DW-1:0] DEB_LOAD = DW'(DEB_CYC - 1);

  typedef enum logic [2:0] {CLOSED, IDLE, ARMED, DEBOUNCE, CAST, RELEASE} state_t;

  state_t           state, state_nx;
  logic [TW-1:0]    tmo_cnt, tmo_nx, tmo_dec;
  logic [DW-1:0]    deb_cnt, deb_nx;
  logic [2:0]       cand, cand_nx;
  logic             block, block_nx;
  logic [2:0]       vote_nx;
  logic             tmo_pulse;
  logic [CNT_W-1:0] voters_nx, rejects_nx;
  logic [2:0]       btn;
  logic             multi, onehot;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign btn     = {btn_C, btn_B, btn_A};
  assign multi   = (btn & (btn - 3'd1)) != 3'd0;
  assign onehot  = (btn != 3'd0) && !multi;
  assign tmo_dec = (tmo_cnt == '0) ? '0 : tmo_cnt - TW'(1);

  always_comb begin
    state_nx   = state;
    tmo_nx     = tmo_cnt;
    deb_nx     = deb_cnt;
    cand_nx    = cand;
    block_nx   = block;
    vote_nx    = 3'b000;
    tmo_pulse  = 1'b0;
    voters_nx  = voters;
    rejects_nx = rejects;
    if (sess_close) begin
      state_nx = CLOSED;
    end else begin
      case (state)
        CLOSED: if (sess_open) begin
          state_nx   = IDLE;
          voters_nx  = '0;
          rejects_nx = '0;
        end
        IDLE: if (voter_auth) begin
          state_nx = ARMED;
          tmo_nx   = TMO_LOAD;
          block_nx = 1'b0;
        end
        ARMED: begin
          // After a multi-press, nothing is accepted until every button is released.
          if (btn == 3'b000) begin
            block_nx = 1'b0;
            if (tmo_cnt == '0) begin
              state_nx  = IDLE;
              tmo_pulse = 1'b1;
            end else begin
              tmo_nx = tmo_dec;
            end
          end else begin
            tmo_nx = tmo_dec;
            if (!block) begin
              if (onehot) begin
                state_nx = DEBOUNCE;
                cand_nx  = btn;
                deb_nx   = DEB_LOAD;
              end else begin
                rejects_nx = sat_inc(rejects);
                block_nx   = 1'b1;
              end
            end
          end
        end
        DEBOUNCE: begin
          tmo_nx = tmo_dec;
          if (tmo_cnt == '0) begin
            state_nx  = IDLE;
            tmo_pulse = 1'b1;
          end else if (btn != cand) begin
            state_nx = ARMED;
            if (multi) begin
              rejects_nx = sat_inc(rejects);
              block_nx   = 1'b1;
            end
          end else if (deb_cnt == '0) begin
            state_nx = CAST;
          end else begin
            deb_nx = deb_cnt - DW'(1);
          end
        end
        CAST: begin
          vote_nx   = cand;
          voters_nx = sat_inc(voters);
          state_nx  = RELEASE;
        end
        RELEASE: if (btn == 3'b000) state_nx = IDLE;
        default: state_nx = CLOSED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= CLOSED;
      block       <= 1'b0;
      vote_A      <= 1'b0;
      vote_B      <= 1'b0;
      vote_C      <= 1'b0;
      ready_led   <= 1'b0;
      sess_active <= 1'b0;
      timeout     <= 1'b0;
      voters      <= '0;
      rejects     <= '0;
    end else begin
      state       <= state_nx;
      block       <= block_nx;
      vote_A      <= vote_nx[0];
      vote_B      <= vote_nx[1];
      vote_C      <= vote_nx[2];
      ready_led   <= (state_nx == ARMED) || (state_nx == DEBOUNCE);
      sess_active <= (state_nx != CLOSED);
      timeout     <= tmo_pulse;
      voters      <= voters_nx;
      rejects     <= rejects_nx;
    end
  end

  // Counters and candidate are always loaded before they are consulted.
  always_ff @(posedge clk) begin
    tmo_cnt <= tmo_nx;
    deb_cnt <= deb_nx;
    cand    <= cand_nx;
  end

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Bench for vote_session_ctrl: vector table, directed corner sequences and
// randomized traffic compared every cycle against a timestamp-based ballot model.
module tb_vote_session_ctrl;

  localparam int DEB = 4;
  localparam int TMO = 16;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sess_open = 1'b0, sess_close = 1'b0, voter_auth = 1'b0;
  logic btn_A = 1'b0, btn_B = 1'b0, btn_C = 1'b0;
  logic vote_A, vote_B, vote_C, ready_led, sess_active, timeout;
  logic [CW-1:0] voters, rejects;

  vote_session_ctrl #(.DEB_CYC(DEB), .TMO_CYC(TMO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .sess_open(sess_open), .sess_close(sess_close),
    .voter_auth(voter_auth), .btn_A(btn_A), .btn_B(btn_B), .btn_C(btn_C),
    .vote_A(vote_A), .vote_B(vote_B), .vote_C(vote_C), .ready_led(ready_led),
    .sess_active(sess_active), .timeout(timeout), .voters(voters), .rejects(rejects)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // Reference model: ballot progress measured in absolute edge numbers.
  localparam int M_CLOSED = 0, M_IDLE = 1, M_ARMED = 2, M_PRESS = 3, M_CAST = 4, M_REL = 5;
  int m_phase = M_CLOSED;
  int m_deadline, m_press;
  logic [2:0] m_cand;
  bit m_blocked;
  int m_voters = 0, m_rejects = 0;
  logic [2:0] m_vote = 3'b000;
  bit m_tmo = 1'b0;

  function automatic int sat(input int v);
    return (v > (1 << CW) - 1) ? (1 << CW) - 1 : v;
  endfunction

  task automatic model_reset();
    m_phase = M_CLOSED; m_voters = 0; m_rejects = 0; m_vote = 3'b000; m_tmo = 1'b0;
    m_blocked = 1'b0;
  endtask

  task automatic model_edge();
    logic [2:0] b;
    b = {btn_C, btn_B, btn_A};
    m_vote = 3'b000;
    m_tmo  = 1'b0;
    if (sess_close) m_phase = M_CLOSED;
    else if (m_phase == M_CLOSED) begin
      if (sess_open) begin m_phase = M_IDLE; m_voters = 0; m_rejects = 0; end
    end else if (m_phase == M_IDLE) begin
      if (voter_auth) begin m_phase = M_ARMED; m_deadline = cyc + TMO; m_blocked = 1'b0; end
    end else if (m_phase == M_ARMED) begin
      if (b == 3'b000) begin
        m_blocked = 1'b0;
        if (cyc >= m_deadline) begin m_phase = M_IDLE; m_tmo = 1'b1; end
      end else if (!m_blocked) begin
        if ($countones(b) == 1) begin m_phase = M_PRESS; m_cand = b; m_press = cyc; end
        else begin m_rejects = sat(m_rejects + 1); m_blocked = 1'b1; end
      end
    end else if (m_phase == M_PRESS) begin
      if (cyc >= m_deadline) begin m_phase = M_IDLE; m_tmo = 1'b1; end
      else if (b != m_cand) begin
        m_phase = M_ARMED;
        if ($countones(b) > 1) begin m_rejects = sat(m_rejects + 1); m_blocked = 1'b1; end
      end else if (cyc - m_press == DEB) m_phase = M_CAST;
    end else if (m_phase == M_CAST) begin
      m_vote = m_cand; m_voters = sat(m_voters + 1); m_phase = M_REL;
    end else if (m_phase == M_REL) begin
      if (b == 3'b000) m_phase = M_IDLE;
    end
  endtask

  function automatic logic [21:0] model_vec();
    return {m_vote, m_tmo, (m_phase == M_ARMED || m_phase == M_PRESS),
            (m_phase != M_CLOSED), CW'(m_voters), CW'(m_rejects)};
  endfunction

  function automatic logic [21:0] dut_vec();
    return {vote_C, vote_B, vote_A, timeout, ready_led, sess_active, voters, rejects};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!reset) model_reset(); else model_edge();
    #1;
    check("model", 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic drive(input logic so, input logic sc, input logic au, input logic [2:0] b);
    sess_open = so; sess_close = sc; voter_auth = au;
    {btn_C, btn_B, btn_A} = b;
  endtask

  typedef struct {
    logic so, sc, au;
    logic [2:0] b;
    logic [2:0] v;
    logic t, r, a;
    logic [7:0] vo, rj;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic so, sc, au, input logic [2:0] b, input logic [2:0] v,
                     input logic t, r, a, input logic [7:0] vo, rj);
    vec_t e;
    e.so = so; e.sc = sc; e.au = au; e.b = b; e.v = v; e.t = t; e.r = r; e.a = a;
    e.vo = vo; e.rj = rj;
    tbl.push_back(e);
  endtask

  int auth_cyc, pulses, vote_cnt;

  initial begin
    //   so sc au btn     vote   t  r  a  voters rejects
    add(1, 0, 0, 3'b000, 3'b000, 0, 0, 1, 0, 0);
    add(0, 0, 1, 3'b000, 3'b000, 0, 1, 1, 0, 0);
    add(0, 0, 0, 3'b010, 3'b000, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 3'b010, 3'b000, 0, 1, 1, 0, 0);
    add(0, 0, 0, 3'b010, 3'b000, 0, 0, 1, 0, 0);
    add(0, 0, 0, 3'b010, 3'b010, 0, 0, 1, 1, 0);
    add(0, 0, 0, 3'b010, 3'b000, 0, 0, 1, 1, 0);
    add(0, 0, 0, 3'b000, 3'b000, 0, 0, 1, 1, 0);
    add(0, 0, 1, 3'b000, 3'b000, 0, 1, 1, 1, 0);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 3'b101, 3'b000, 0, 1, 1, 1, 1);
    add(0, 0, 0, 3'b000, 3'b000, 0, 1, 1, 1, 1);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 3'b100, 3'b000, 0, 1, 1, 1, 1);
    add(0, 0, 0, 3'b100, 3'b000, 0, 0, 1, 1, 1);
    add(0, 0, 0, 3'b100, 3'b100, 0, 0, 1, 2, 1);
    add(0, 0, 0, 3'b000, 3'b000, 0, 0, 1, 2, 1);
    add(1, 0, 0, 3'b000, 3'b000, 0, 0, 1, 2, 1);
    add(0, 0, 0, 3'b010, 3'b000, 0, 0, 1, 2, 1);
    add(1, 1, 0, 3'b000, 3'b000, 0, 0, 0, 2, 1);
    add(0, 0, 1, 3'b000, 3'b000, 0, 0, 0, 2, 1);
    add(0, 0, 0, 3'b001, 3'b000, 0, 0, 0, 2, 1);
    add(1, 0, 0, 3'b000, 3'b000, 0, 0, 1, 0, 0);

    step(); step();
    check("reset_state", 32'(dut_vec()), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].so, tbl[i].sc, tbl[i].au, tbl[i].b);
      step();
      check($sformatf("row%0d", i), 32'(dut_vec()),
            32'({tbl[i].v, tbl[i].t, tbl[i].r, tbl[i].a, tbl[i].vo, tbl[i].rj}));
    end
    drive(0, 0, 0, 3'b000);

    // Short press then nothing: ballot expires TMO cycles after authorisation.
    drive(0, 0, 1, 3'b000); step(); auth_cyc = cyc;
    drive(0, 0, 0, 3'b001); step(); step();
    drive(0, 0, 0, 3'b000);
    vote_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (vote_A | vote_B | vote_C) vote_cnt++;
      if (timeout) break;
    end
    check("tmo_latency", 32'(cyc - auth_cyc), 32'(TMO));
    check("tmo_no_vote", 32'(vote_cnt), 32'd0);
    check("tmo_idle", 32'({ready_led, sess_active}), 32'b01);

    // Held button with a stray authorisation during the hold.
    drive(0, 0, 1, 3'b000); step();
    drive(0, 0, 0, 3'b001); step();
    pulses = 0;
    for (int i = 0; i < 45; i++) begin
      voter_auth = (i == 20);
      step();
      if (vote_A | vote_B | vote_C) pulses++;
      if (i == 20) check("auth_in_release", 32'(ready_led), 32'd0);
    end
    check("hold_one_pulse", 32'(pulses), 32'd1);
    drive(0, 0, 0, 3'b000); step();
    drive(0, 0, 1, 3'b000); step();
    check("auth_after_release", 32'(ready_led), 32'd1);
    drive(0, 0, 0, 3'b000);
    for (int i = 0; i < TMO + 1; i++) step();

    // Close coincides with the CAST cycle.
    drive(0, 0, 1, 3'b000); step();
    drive(0, 0, 0, 3'b010); step();
    for (int i = 0; i < DEB; i++) step();
    sess_close = 1'b1; step();
    check("close_cast", 32'({vote_C, vote_B, vote_A, sess_active, voters}), 32'({3'b000, 1'b0, 8'd1}));
    drive(0, 0, 1, 3'b010); step(); step();
    voter_auth = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("closed_ignores", 32'({sess_active, voters}), 32'({1'b0, 8'd1}));
    drive(1, 0, 0, 3'b000); step();
    check("reopen_clear", 32'({sess_active, voters, rejects}), 32'({1'b1, 16'd0}));
    sess_open = 1'b0;

    // Asynchronous reset in the middle of a debounce.
    drive(0, 0, 1, 3'b000); step();
    drive(0, 0, 0, 3'b100); step(); step();
    reset = 1'b0; #1;
    check("rst_async", 32'(dut_vec()), 32'd0);
    model_reset();
    step(); step();
    reset = 1'b1;
    vote_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) btn_C = 1'b0;
      step();
      if (vote_A | vote_B | vote_C) vote_cnt++;
    end
    check("rst_no_vote", 32'(vote_cnt), 32'd0);
    drive(1, 0, 0, 3'b000); step();
    drive(0, 0, 1, 3'b000); step();
    drive(0, 0, 0, 3'b010); for (int i = 0; i < DEB + 2; i++) step();
    drive(0, 0, 0, 3'b000); step();
    check("fresh_count", 32'(voters), 32'd1);

    // Saturation of the voter tally.
    for (int k = 0; k < 260; k++) begin
      drive(0, 0, 1, 3'b000); step();
      drive(0, 0, 0, 3'b001); for (int i = 0; i < DEB + 2; i++) step();
      drive(0, 0, 0, 3'b000); step();
    end
    check("voters_sat", 32'(voters), 32'd255);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int r;
      sess_close = ($urandom_range(0, 39) == 0);
      sess_open  = ($urandom_range(0, 5) == 0);
      voter_auth = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 5) == 0) begin
        r = $urandom_range(0, 99);
        if (r < 40) {btn_C, btn_B, btn_A} = 3'b000;
        else if (r < 85) {btn_C, btn_B, btn_A} = 3'b001 << $urandom_range(0, 2);
        else {btn_C, btn_B, btn_A} = 3'(3 + $urandom_range(0, 1) * 2 + $urandom_range(0, 1));
      end
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b0; #1;
        check("rst_rand", 32'(dut_vec()), 32'd0);
        model_reset();
        step();
        reset = 1'b1;
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
